// File: rtl/ext_interleaver.sv
// Extrinsic exchange stage: scales/clamps 7 SISO LLR lanes, permutes them (interleave or
// de-interleave by half-iteration parity) and buffers the result in a 2-entry FIFO.
module ext_interleaver #(
  parameter int unsigned LANES      = 7,
  parameter int unsigned LLR_W      = 12,
  parameter int unsigned EXT_SAT    = 1023,
  parameter int unsigned SCALE_EN   = 1,
  parameter int unsigned HALF_ITERS = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   valid_i,
  input  logic [LANES*LLR_W-1:0] data_i,
  output logic                   in_ready_o,
  output logic [LANES*LLR_W-1:0] ext_o,
  output logic                   ext_valid_o,
  input  logic                   ext_ready_i,
  output logic                   dir_o,
  output logic                   last_o,
  output logic                   overflow_o
);

  localparam int unsigned DW = LANES * LLR_W;
  localparam int unsigned CW = (HALF_ITERS > 1) ? $clog2(HALF_ITERS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HALF_ITERS - 1);
  localparam logic signed [LLR_W:0] SAT_P = (LLR_W + 1)'(EXT_SAT);
  localparam logic signed [LLR_W:0] SAT_N = -SAT_P;
  localparam int unsigned PERM_IL [7] = '{3, 0, 5, 1, 6, 2, 4};
  localparam int unsigned PERM_DI [7] = '{1, 3, 5, 0, 6, 2, 4};

  logic [CW-1:0]   half_cnt;
  logic            dir;
  logic            s1_valid;
  logic [DW-1:0]   s1_data;
  logic            s1_dir;
  logic            s1_last;
  logic [DW-1:0]   mem_data [2];
  logic [1:0]      mem_dir;
  logic [1:0]      mem_last;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [DW-1:0]   scaled;
  logic [DW-1:0]   permuted;
  logic signed [LLR_W:0] x_ext [LANES];
  logic signed [LLR_W:0] y_scl [LANES];
  logic            accept;
  logic            push;
  logic            pop;
  logic [1:0]      count_next;

  // 13-bit intermediate keeps x - (x >>> 2) exact before the clamp.
  always_comb begin
    scaled = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      x_ext[k] = (LLR_W + 1)'($signed(data_i[k*LLR_W +: LLR_W]));
      y_scl[k] = (SCALE_EN != 0) ? (x_ext[k] - (x_ext[k] >>> 2)) : x_ext[k];
      if (y_scl[k] > SAT_P)
        y_scl[k] = SAT_P;
      else if (y_scl[k] < SAT_N)
        y_scl[k] = SAT_N;
      scaled[k*LLR_W +: LLR_W] = y_scl[k][LLR_W-1:0];
    end
  end

  always_comb begin
    permuted = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (s1_dir)
        permuted[k*LLR_W +: LLR_W] = s1_data[PERM_DI[k]*LLR_W +: LLR_W];
      else
        permuted[k*LLR_W +: LLR_W] = s1_data[PERM_IL[k]*LLR_W +: LLR_W];
    end
  end

  assign in_ready_o  = (count + {1'b0, s1_valid}) < 2'd2;
  assign ext_valid_o = (count != 2'd0);
  assign ext_o       = mem_data[rd_ptr];
  assign dir_o       = mem_dir[rd_ptr];
  assign last_o      = mem_last[rd_ptr];

  assign accept = valid_i && in_ready_o;
  assign pop    = ext_valid_o && ext_ready_i;
  assign push   = s1_valid && ((count != 2'd2) || pop);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overflow_o  <= 1'b0;
      half_cnt    <= '0;
      dir         <= 1'b0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_dir      <= 1'b0;
      s1_last     <= 1'b0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_dir     <= '0;
      mem_last    <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
    end else if (start_i) begin
      // Codeword restart clears everything except the sticky overflow flag.
      half_cnt    <= '0;
      dir         <= 1'b0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_dir      <= 1'b0;
      s1_last     <= 1'b0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_dir     <= '0;
      mem_last    <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
    end else begin
      if (valid_i && !in_ready_o)
        overflow_o <= 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_data <= scaled;
        s1_dir  <= dir;
        s1_last <= (half_cnt == LAST_CNT);
        if (half_cnt == LAST_CNT) begin
          half_cnt <= '0;
          dir      <= 1'b0;
        end else begin
          half_cnt <= half_cnt + 1'b1;
          dir      <= ~dir;
        end
      end
      if (push) begin
        mem_data[wr_ptr] <= permuted;
        mem_dir[wr_ptr]  <= s1_dir;
        mem_last[wr_ptr] <= s1_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

endmodule
